// File: rtl/des_region_sweeper.sv
// Command sequencer for the DES block wrapper: walks a region range, issuing
// READ_REGION / START / RESTART per region and queueing {region, counter} results.
module des_region_sweeper #(
    parameter int REGION_W   = 16,
    parameter int CTR_W      = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sweep_start,
    input  logic                sweep_abort,
    input  logic [REGION_W-1:0] region_first,
    input  logic [REGION_W-1:0] region_last,
    output logic                sweep_busy,
    output logic                sweep_done,
    output logic [REGION_W:0]   regions_done,
    output logic [31:0]         des_cmd,
    output logic                des_cmd_valid,
    output logic [REGION_W-1:0] des_region,
    input  logic                des_cmd_read,
    input  logic                des_done,
    input  logic [CTR_W-1:0]    des_counter,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [REGION_W-1:0] res_region,
    output logic [CTR_W-1:0]    res_counter
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0]       CMD_READ    = 32'd0;
    localparam logic [31:0]       CMD_START   = 32'd1;
    localparam logic [31:0]       CMD_RESTART = 32'd3;
    localparam logic [REGION_W-1:0] REG_ONE   = 1;
    localparam logic [REGION_W:0]   CNT_ONE   = 1;
    localparam logic [AW-1:0]       PTR_ONE   = 1;
    localparam logic [AW:0]         OCC_ONE   = 1;
    localparam logic [AW:0]         OCC_FULL  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, GAP_L, START, WAIT, CAPT, RESTART, NEXT} state_t;

    state_t              state;
    logic [REGION_W-1:0] cur, last;
    logic                abort_q;

    logic [REGION_W-1:0] mem_region [FIFO_DEPTH];
    logic [CTR_W-1:0]    mem_ctr    [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         occ;
    logic                full, push, pop;

    assign full        = (occ == OCC_FULL);
    assign res_valid   = (occ != '0);
    assign push        = (state == CAPT) && !full;
    assign pop         = res_valid && res_ready;
    assign res_region  = mem_region[rd_ptr];
    assign res_counter = mem_ctr[rd_ptr];

    // Storage has no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_region[wr_ptr] <= cur;
            mem_ctr[wr_ptr]    <= des_counter;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      occ <= occ + OCC_ONE;
            else if (pop && !push) occ <= occ - OCC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cur           <= '0;
            last          <= '0;
            abort_q       <= 1'b0;
            des_cmd       <= CMD_READ;
            des_cmd_valid <= 1'b0;
            des_region    <= '0;
            sweep_busy    <= 1'b0;
            sweep_done    <= 1'b0;
            regions_done  <= '0;
        end else begin
            sweep_done <= 1'b0;
            if (state != IDLE && sweep_abort) abort_q <= 1'b1;
            case (state)
                IDLE: if (sweep_start) begin
                    cur           <= region_first;
                    last          <= region_last;
                    regions_done  <= '0;
                    sweep_busy    <= 1'b1;
                    des_cmd       <= CMD_READ;
                    des_region    <= region_first;
                    des_cmd_valid <= 1'b1;
                    state         <= LOAD;
                end
                LOAD: if (des_cmd_read) begin
                    des_cmd_valid <= 1'b0;
                    state         <= GAP_L;
                end
                GAP_L: begin
                    des_cmd       <= CMD_START;
                    des_cmd_valid <= 1'b1;
                    state         <= START;
                end
                START: if (des_cmd_read) begin
                    des_cmd_valid <= 1'b0;
                    state         <= WAIT;
                end
                WAIT: if (des_done) state <= CAPT;
                // Counter is valid from here on; a full FIFO holds us while the wrapper keeps it stable.
                CAPT: if (!full) begin
                    regions_done  <= regions_done + CNT_ONE;
                    des_cmd       <= CMD_RESTART;
                    des_cmd_valid <= 1'b1;
                    state         <= RESTART;
                end
                RESTART: if (des_cmd_read) begin
                    des_cmd_valid <= 1'b0;
                    state         <= NEXT;
                end
                NEXT: if (cur == last || abort_q || sweep_abort) begin
                    sweep_busy <= 1'b0;
                    sweep_done <= 1'b1;
                    abort_q    <= 1'b0;
                    state      <= IDLE;
                end else begin
                    cur           <= cur + REG_ONE;
                    des_region    <= cur + REG_ONE;
                    des_cmd       <= CMD_READ;
                    des_cmd_valid <= 1'b1;
                    state         <= LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_region_sweeper.sv
// Bench for des_region_sweeper: behavioural wrapper model with random ack delays,
// result scoreboard, directed sweeps covering wrap, stall, abort and mid-sweep reset.
module tb_des_region_sweeper;
    localparam int RW = 16;
    localparam int CW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sweep_start = 1'b0, sweep_abort = 1'b0;
    logic [RW-1:0] region_first = '0, region_last = '0;
    logic          sweep_busy, sweep_done;
    logic [RW:0]   regions_done;
    logic [31:0]   des_cmd;
    logic          des_cmd_valid;
    logic [RW-1:0] des_region;
    logic          des_cmd_read = 1'b0, des_done = 1'b0;
    logic [CW-1:0] des_counter = '0;
    logic          res_valid, res_ready = 1'b0;
    logic [RW-1:0] res_region;
    logic [CW-1:0] res_counter;

    des_region_sweeper #(.REGION_W(RW), .CTR_W(CW), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .sweep_start(sweep_start), .sweep_abort(sweep_abort),
        .region_first(region_first), .region_last(region_last),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done), .regions_done(regions_done),
        .des_cmd(des_cmd), .des_cmd_valid(des_cmd_valid), .des_region(des_region),
        .des_cmd_read(des_cmd_read), .des_done(des_done), .des_counter(des_counter),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_region(res_region), .res_counter(res_counter)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RW-1:0] region;
        logic [CW-1:0] ctr;
    } res_t;

    res_t          sb[$];
    int            vectors = 0, miscompares = 0;
    int            done_timer = 0, restart_cnt = 0, ack_total = 0;
    logic [RW-1:0] exp_base = '0;

    function automatic logic [CW-1:0] ctr_of(input logic [RW-1:0] r);
        logic [CW-1:0] x;
        x = 64'(r ^ 16'd5);
        return 64'h1234 ^ (x << 20);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Wrapper model and result monitor; drives at negedge, DUT samples at posedge.
    initial begin : wrapper
        logic          seen, ctr_ok;
        logic [31:0]   hold_cmd, exp_cmd;
        logic [RW-1:0] hold_region, wr_region, exp_region;
        int            dly;
        res_t          e;
        seen = 1'b0; ctr_ok = 1'b0; hold_cmd = '0; exp_cmd = '0;
        hold_region = '0; wr_region = '0; dly = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                des_cmd_read = 1'b0; des_done = 1'b0; des_counter = '0;
                done_timer = 0; restart_cnt = 0; seen = 1'b0; ctr_ok = 1'b0; exp_cmd = '0;
            end else begin
                if (!sweep_busy) restart_cnt = 0;
                if (res_valid && res_ready) begin
                    if (sb.size() != 0) e = sb.pop_front();
                    else e = '1;
                    check("res_region", 64'(res_region), 64'(e.region));
                    check("res_counter", res_counter, e.ctr);
                end
                if (des_cmd_read) begin
                    des_cmd_read = 1'b0;
                    check("valid_drop_after_ack", 64'(des_cmd_valid), 64'd0);
                end else if (des_cmd_valid) begin
                    if (!seen) begin
                        seen = 1'b1; hold_cmd = des_cmd; hold_region = des_region;
                        dly = int'($urandom_range(0, 5));
                    end else begin
                        check("cmd_stable", 64'(des_cmd), 64'(hold_cmd));
                        check("region_stable", 64'(des_region), 64'(hold_region));
                    end
                    if (dly == 0) begin
                        des_cmd_read = 1'b1; seen = 1'b0; ack_total++;
                        check("cmd_order", 64'(des_cmd), 64'(exp_cmd));
                        case (des_cmd)
                            32'd0: begin
                                exp_region = exp_base + RW'(restart_cnt);
                                check("load_region", 64'(des_region), 64'(exp_region));
                                wr_region = des_region; exp_cmd = 32'd1;
                            end
                            32'd1: begin done_timer = 10; exp_cmd = 32'd3; end
                            default: begin
                                des_done = 1'b0; ctr_ok = 1'b0; des_counter = 64'hDEAD_DEAD_DEAD_DEAD;
                                exp_cmd = 32'd0; restart_cnt++;
                            end
                        endcase
                    end else dly--;
                end
                if (des_done && !ctr_ok) begin des_counter = ctr_of(wr_region); ctr_ok = 1'b1; end
                if (done_timer > 0) begin
                    done_timer--;
                    if (done_timer == 0) begin
                        des_done = 1'b1; ctr_ok = 1'b0; des_counter = 64'hBAD0_BAD0_BAD0_BAD0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic start_sweep(input logic [RW-1:0] f, input logic [RW-1:0] l);
        region_first = f; region_last = l; exp_base = f;
        sweep_start = 1'b1; step(); sweep_start = 1'b0;
    endtask

    task automatic push_exp(input logic [RW-1:0] f, input int n);
        res_t e;
        for (int i = 0; i < n; i++) begin
            e.region = f + RW'(i);
            e.ctr    = ctr_of(e.region);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!sweep_done && n < budget) begin step(); n++; end
        check(tag, 64'(sweep_done), 64'd1);
        check({tag, "_busy_low"}, 64'(sweep_busy), 64'd0);
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        res_ready = 1'b1;
        while (sb.size() != 0 && n < budget) begin step(); n++; end
        check(tag, 64'(sb.size()), 64'd0);
        check({tag, "_empty"}, 64'(res_valid), 64'd0);
    endtask

    initial begin : main
        int a0, n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(sweep_busy), 64'd0);
        check("rst_done", 64'(sweep_done), 64'd0);
        check("rst_valid", 64'(des_cmd_valid), 64'd0);
        check("rst_cmd", 64'(des_cmd), 64'd0);
        check("rst_region", 64'(des_region), 64'd0);
        check("rst_regions_done", 64'(regions_done), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        rst_n = 1'b1;
        step();

        // single region, result left in FIFO until drained
        a0 = ack_total;
        push_exp(16'd5, 1);
        start_sweep(16'd5, 16'd5);
        check("t1_busy", 64'(sweep_busy), 64'd1);
        wait_done(300, "t1_done");
        check("t1_regions_done", 64'(regions_done), 64'd1);
        check("t1_acks", 64'(ack_total - a0), 64'd3);
        check("t1_res_valid", 64'(res_valid), 64'd1);
        step();
        check("t1_done_pulse", 64'(sweep_done), 64'd0);
        drain(50, "t1_drain");

        // wrap through max, with a start pulse while busy that must be ignored
        res_ready = 1'b1;
        push_exp(16'hFFFE, 4);
        start_sweep(16'hFFFE, 16'h0001);
        repeat (3) step();
        region_first = 16'd100; region_last = 16'd200; sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        wait_done(600, "t2_done");
        check("t2_regions_done", 64'(regions_done), 64'd4);
        drain(50, "t2_drain");

        // ten regions into an eight-entry FIFO with no reader
        res_ready = 1'b0;
        push_exp(16'h0010, 10);
        start_sweep(16'h0010, 16'h0019);
        n = 0;
        while (regions_done != 17'd8 && n < 2000) begin step(); n++; end
        check("t3_reach8", 64'(regions_done), 64'd8);
        repeat (30) step();
        check("t3_stall_count", 64'(regions_done), 64'd8);
        check("t3_stall_done_held", 64'(des_done), 64'd1);
        check("t3_stall_busy", 64'(sweep_busy), 64'd1);
        check("t3_stall_valid", 64'(des_cmd_valid), 64'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t3_pop_cycle", 64'(regions_done), 64'd8);
        step();
        check("t3_ninth_pushed", 64'(regions_done), 64'd9);
        res_ready = 1'b1;
        wait_done(600, "t3_done");
        check("t3_regions_done", 64'(regions_done), 64'd10);
        drain(50, "t3_drain");

        // abort while waiting on region 2 of 0..9
        res_ready = 1'b1;
        a0 = ack_total;
        push_exp(16'd0, 3);
        start_sweep(16'd0, 16'd9);
        n = 0;
        while (!(restart_cnt == 2 && done_timer > 0) && n < 1000) begin step(); n++; end
        check("t4_reach_wait", 64'(restart_cnt == 2 && done_timer > 0), 64'd1);
        sweep_abort = 1'b1;
        step();
        sweep_abort = 1'b0;
        wait_done(300, "t4_done");
        check("t4_regions_done", 64'(regions_done), 64'd3);
        check("t4_acks", 64'(ack_total - a0), 64'd9);
        drain(50, "t4_drain");

        // reset pulse while waiting on the second region
        res_ready = 1'b0;
        start_sweep(16'h0040, 16'h0045);
        n = 0;
        while (!(restart_cnt == 1 && done_timer > 0) && n < 1000) begin step(); n++; end
        check("t5_reach_wait", 64'(restart_cnt == 1 && done_timer > 0), 64'd1);
        check("t5_fifo_nonempty", 64'(res_valid), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t5_busy", 64'(sweep_busy), 64'd0);
        check("t5_done", 64'(sweep_done), 64'd0);
        check("t5_valid", 64'(des_cmd_valid), 64'd0);
        check("t5_cmd", 64'(des_cmd), 64'd0);
        check("t5_region", 64'(des_region), 64'd0);
        check("t5_regions_done", 64'(regions_done), 64'd0);
        check("t5_res_valid", 64'(res_valid), 64'd0);
        step();

        // abort in IDLE has no effect on the following sweep
        sweep_abort = 1'b1;
        step();
        sweep_abort = 1'b0;
        res_ready = 1'b1;
        push_exp(16'd7, 2);
        start_sweep(16'd7, 16'd8);
        wait_done(300, "t6_done");
        check("t6_regions_done", 64'(regions_done), 64'd2);
        drain(50, "t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
